ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: tracks EX/MEM/WB occupancy, detects load-use and
// taken-branch hazards, freezes on slow loads and selects operand forwarding.
module ex_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t state_q, state_d;

  // _p0 = EX, _p1 = MEM, _p2 = WB
  logic              vld_p0, we_p0, ld_p0, re1_p0, re2_p0;
  logic [REG_AW-1:0] rd_p0, rs1_p0, rs2_p0;
  logic              vld_p1, we_p1, ld_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              vld_p2, we_p2;
  logic [REG_AW-1:0] rd_p2;

  logic freeze, br_flush, lu_hazard;

  function automatic logic [1:0] fwd_src(
    input logic              re,
    input logic [REG_AW-1:0] rs,
    input logic              m_vld,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_vld,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (re && m_vld && m_we && (m_rd != '0) && (m_rd == rs))
      sel = 2'b01;
    else if (re && w_vld && w_we && (w_rd != '0) && (w_rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  assign freeze    = vld_p1 & ld_p1 & ~mem_ready;
  assign br_flush  = vld_p0 & ex_br_taken;
  assign lu_hazard = id_valid & vld_p0 & ld_p0 & we_p0 & (rd_p0 != '0) &
                     ((id_re1 & (id_rs1 == rd_p0)) | (id_re2 & (id_rs2 == rd_p0)));

  // A frozen pipeline holds everything, so a pending branch flush waits for release.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (br_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign fwd_a_sel = fwd_src(re1_p0, rs1_p0, vld_p1, we_p1, rd_p1, vld_p2, we_p2, rd_p2);
  assign fwd_b_sel = fwd_src(re2_p0, rs2_p0, vld_p1, we_p1, rd_p1, vld_p2, we_p2, rd_p2);

  // Stage boundary ID->EX->MEM->WB: control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      we_p0  <= 1'b0;
      ld_p0  <= 1'b0;
      re1_p0 <= 1'b0;
      re2_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      ld_p1  <= 1'b0;
      vld_p2 <= 1'b0;
      we_p2  <= 1'b0;
    end else if (!freeze) begin
      vld_p0 <= id_valid   & ~id_ex_flush;
      we_p0  <= id_rf_we   & ~id_ex_flush;
      ld_p0  <= id_is_load & ~id_ex_flush;
      re1_p0 <= id_re1     & ~id_ex_flush;
      re2_p0 <= id_re2     & ~id_ex_flush;
      vld_p1 <= vld_p0;
      we_p1  <= we_p0;
      ld_p1  <= ld_p0;
      vld_p2 <= vld_p1;
      we_p2  <= we_p1;
    end
  end

  // Stage boundary ID->EX->MEM->WB: register addresses
  always_ff @(posedge clk) begin
    if (!freeze) begin
      rd_p0  <= id_rd;
      rs1_p0 <= id_rs1;
      rs2_p0 <= id_rs2;
      rd_p1  <= rd_p0;
      rd_p2  <= rd_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
                else if (lu_hazard && !br_flush) state_d = LU_STALL;
      LU_STALL: if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (freeze) state_d = MEM_WAIT;
      default:  state_d = RUN;
    endcase
  end

  assign state     = state_q;
  assign ex_valid  = vld_p0;
  assign mem_valid = vld_p1;
  assign wb_valid  = vld_p2;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed table-driven bench for ex_hazard_ctrl plus hand sequences for
// slow-load freeze and reset during a freeze.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_re1, id_re2, id_rf_we, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_br_taken, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;
  logic       ex_valid, mem_valid, wb_valid;
  logic [12:0] act;

  int n_chk = 0;
  int n_fail = 0;

  ex_hazard_ctrl #(.REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .state(state)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, fwd_a, fwd_b, ex_v, mem_v, wb_v, state}
  assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel,
                ex_valid, mem_valid, wb_valid, state};

  typedef struct {
    logic       v, re1, re2, we, ld, br, mr;
    logic [4:0] rs1, rs2, rd;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int re1,
                              input int re2, input int rd, input int we, input int ld,
                              input int br, input int mr, input logic [12:0] exp);
    vec_t t;
    t.v = (v != 0); t.re1 = (re1 != 0); t.re2 = (re2 != 0);
    t.we = (we != 0); t.ld = (ld != 0); t.br = (br != 0); t.mr = (mr != 0);
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.exp = exp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_re1 = t.re1; id_re2 = t.re2;
    id_rd = t.rd; id_rf_we = t.we; id_is_load = t.ld;
    ex_br_taken = t.br; mem_ready = t.mr;
  endtask

  task automatic chk(input string name, input logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // ID contents:         v rs1 rs2 re1 re2 rd we ld br mr  expected
    tbl[0]  = mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 1, 13'b0000_00_00_000_00); // lw x5
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 13'b1101_00_00_100_00); // add x6,x5,x1
    tbl[2]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 13'b0000_00_00_010_01);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_10_00_101_00);
    tbl[4]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 13'b0000_00_00_010_00); // add x3
    tbl[5]  = mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 1, 13'b0000_00_00_101_00); // sub x4,x3,x3
    tbl[6]  = mk(1, 9, 3, 1, 1, 8, 1, 0, 0, 1, 13'b0000_01_01_110_00); // or x8,x9,x3
    tbl[7]  = mk(1, 1, 1, 1, 1, 3, 1, 0, 0, 1, 13'b0000_00_10_111_00); // add x3
    tbl[8]  = mk(1, 1, 1, 1, 1, 3, 1, 0, 0, 1, 13'b0000_00_00_111_00); // add x3
    tbl[9]  = mk(1, 3, 3, 1, 1, 11, 1, 0, 0, 1, 13'b0000_00_00_111_00); // add x11,x3,x3
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_01_01_111_00);
    tbl[11] = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 1, 13'b0000_00_00_011_00); // add x0
    tbl[12] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 13'b0000_00_00_101_00); // lw x0
    tbl[13] = mk(1, 0, 0, 1, 1, 12, 1, 0, 0, 1, 13'b0000_00_00_110_00); // add x12,x0,x0
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_00_00_111_00);
    tbl[15] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 1, 13'b0000_00_00_011_00); // lw x5
    tbl[16] = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, 1, 13'b0011_00_00_101_00); // branch beats load-use
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_00_00_010_00);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_00_00_001_00);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0000_00_00_000_00);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0));
    @(negedge clk);
    #1 chk("reset_state", 13'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      #1 chk($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge clk);
    end

    // Slow load in MEM for 3 cycles while a taken branch sits in EX.
    drive(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 1, 13'b0)); // lw x7
    @(negedge clk);
    drive(mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 13'b0)); // beq
    @(negedge clk);
    drive(mk(1, 3, 4, 1, 1, 9, 1, 0, 1, 0, 13'b0));
    #1 chk("freeze_c1", 13'b1100_00_00_110_00);
    @(negedge clk);
    #1 chk("freeze_c2", 13'b1100_00_00_110_10);
    @(negedge clk);
    #1 chk("freeze_c3", 13'b1100_00_00_110_10);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("freeze_release_flush", 13'b0011_00_00_110_10);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0));
    #1 chk("after_flush", 13'b0000_00_00_011_00);
    @(negedge clk);

    // Reset asserted while frozen.
    drive(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 1, 13'b0)); // lw x8
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("freeze2_c1", 13'b1100_00_00_010_00);
    @(negedge clk);
    #1 chk("freeze2_c2", 13'b1100_00_00_010_10);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_freeze", 13'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 13'b0));
    #1 chk("post_reset_empty", 13'b0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'b0));
    #1 chk("post_reset_advance", 13'b0000_00_00_100_00);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
